dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the processor's load/store path (address from ALU result, store data from rs2) and a multi-cycle backing data memory.
- Generates the processor's dcache stall signal.
- The processor holds cpu_rd/cpu_wr/cpu_addr/cpu_wdata stable while stall=1.

Parameters:
INDEX_BITS, 4, line index width; number of lines = 2**INDEX_BITS, one 32-bit word per line
CNT_W, 16, width of hit/miss statistics counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
cpu_rd  input  1  load request this cycle
cpu_wr  input  1  store request this cycle
cpu_addr  input  32  byte address; bits [1:0] ignored
cpu_wdata  input  32  store data
cpu_rdata  output  32  load data, valid when cpu_rd=1 and stall=0
stall  output  1  processor must hold its state and request
mem_req  output  1  backing-memory request
mem_wr  output  1  1 = write, 0 = read; valid with mem_req
mem_addr  output  32  word-aligned address {cpu_addr[31:2],2'b00}
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  one-cycle completion pulse
hit_count  output  CNT_W  saturating count of read hits
miss_count  output  CNT_W  saturating count of read misses

Behaviour:
- Address split: index = cpu_addr[INDEX_BITS+1:2]; tag = cpu_addr[31:INDEX_BITS+2].
- Storage per line: valid bit, tag, 32-bit data.
- hit = valid[index] & (tag_array[index] == tag), combinational.
- States:
  - IDLE: no request in flight.
  - RD_MISS: read in flight to memory.
  - WR_THRU: write in flight to memory.
  - DONE: one-cycle completion.
- Transitions from IDLE:
  - cpu_wr=1 → WR_THRU. cpu_wr takes priority if cpu_rd and cpu_wr are both 1; this is treated as a write only.
  - cpu_rd=1 and hit → stay in IDLE. cpu_rdata = line data; stall=0; zero-latency hit; hit_count increments.
  - cpu_rd=1 and miss → RD_MISS. miss_count increments once.
  - Otherwise stay in IDLE.
- Store-hit update: on the IDLE→WR_THRU edge, if the store hits, the line data is updated with cpu_wdata. A store miss does not allocate.
- RD_MISS:
  - mem_req=1, mem_wr=0, mem_addr held.
  - On mem_ack: line is filled (valid=1, tag, mem_rdata), mem_rdata is captured into fill_reg, → DONE.
- WR_THRU:
  - mem_req=1, mem_wr=1, mem_addr/mem_wdata from cpu inputs.
  - On mem_ack → DONE.
- DONE:
  - stall=0; cpu_rdata = fill_reg; request is consumed.
  - Next state is always IDLE, even if a request is still asserted. This prevents re-issuing a completed store.
  - Counters do not change in DONE.
- stall is combinational:
  - 1 in RD_MISS and WR_THRU.
  - 1 in IDLE when (cpu_wr) | (cpu_rd & ~hit).
  - 0 otherwise.
  - For a miss, stall rises in the same cycle as the request.
- mem_req is registered: it asserts the cycle after the request, stays high until and including the mem_ack cycle, and is 0 in IDLE and DONE.
- mem_ack while not in RD_MISS/WR_THRU is ignored.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss or any store: 1 + (cycles until mem_ack) + 0, completing in DONE.
  - With mem_ack on the first mem_req cycle, stall is high for exactly 2 cycles.
- Counters saturate at 2**CNT_W-1 and never wrap.
- cpu_rdata = 0 when neither a hit nor DONE applies.
- Reset (synchronous, any state, including mid-miss):
  - state=IDLE, all valid bits=0, fill_reg=0, counters=0, mem_req=0 after the edge.
  - A mem_ack arriving after reset is ignored.
  - Tag/data arrays need no reset.
- Indices alias by design. A fill to an index replaces the previous tag regardless of its validity.

Test Plan:
1. Reset, then load 0x0000_0040 with mem_ack 3 cycles after mem_req rising and mem_rdata=0xDEAD_BEEF → stall high 4 cycles, cpu_rdata=0xDEAD_BEEF in DONE, miss_count=1; repeat the load → stall=0 same cycle, data 0xDEAD_BEEF, hit_count=1.
2. Store 0x1234_5678 to 0x40 after the fill → mem_req/mem_wr=1, mem_wdata=0x1234_5678; after ack a load of 0x40 hits with 0x1234_5678 and no mem_req.
3. Store to uncached 0x80, then load 0x80 → the store does not allocate; the load misses (miss_count increments, mem read issued).
4. Load 0x40 (fill), then load 0x440 (same index for INDEX_BITS=4, different tag) → miss and replace; a following load of 0x40 misses again.
5. Assert rst during RD_MISS, then pulse mem_ack the next cycle → state IDLE, mem_req=0, no fill, counters 0; load 0x40 misses.
6. cpu_rd and cpu_wr both high for address 0x40 → single write transaction (mem_wr=1), counters unchanged; DONE lasts exactly 1 cycle while the inputs are still asserted, and no second mem_req is issued.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with one word per line.
// Read hits complete with zero stall; misses and stores go to a multi-cycle backing memory.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned Lines = 2 ** INDEX_BITS;
  localparam int unsigned TagW  = 30 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru, StDone} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [Lines-1:0]      r_valid;
  logic [TagW-1:0]       r_tag  [Lines];
  logic [31:0]           r_data [Lines];
  logic [31:0]           r_fill;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic [CNT_W-1:0]      r_miss_cnt;

  logic [INDEX_BITS-1:0] w_index;
  logic [TagW-1:0]       w_tag;
  logic                  w_hit;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_fill;
  logic                  w_store_hit;

  assign w_index = cpu_addr[INDEX_BITS+1:2];
  assign w_tag   = cpu_addr[31:INDEX_BITS+2];
  assign w_hit   = r_valid[w_index] & (r_tag[w_index] == w_tag);

  always_comb begin
    w_state_d   = r_state;
    stall       = 1'b0;
    cpu_rdata   = 32'h0;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    w_fill      = 1'b0;
    w_store_hit = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A simultaneous read and write is treated as a write only.
        if (cpu_wr) begin
          stall       = 1'b1;
          w_store_hit = w_hit;
          w_state_d   = StWrThru;
        end else if (cpu_rd) begin
          if (w_hit) begin
            cpu_rdata = r_data[w_index];
            w_hit_inc = 1'b1;
          end else begin
            stall      = 1'b1;
            w_miss_inc = 1'b1;
            w_state_d  = StRdMiss;
          end
        end
      end
      StRdMiss: begin
        stall = 1'b1;
        if (mem_ack) begin
          w_fill    = 1'b1;
          w_state_d = StDone;
        end
      end
      StWrThru: begin
        stall = 1'b1;
        if (mem_ack) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        // Always return to idle so a still-asserted store is not re-issued.
        cpu_rdata = r_fill;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign mem_req    = (r_state == StRdMiss) | (r_state == StWrThru);
  assign mem_wr     = (r_state == StWrThru);
  assign mem_addr   = {cpu_addr[31:2], 2'b00};
  assign mem_wdata  = cpu_wdata;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_fill     <= 32'h0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_fill           <= mem_rdata;
      end
      if (w_hit_inc && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
      if (w_miss_inc && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_rdata;
      end else if (w_store_hit) begin
        r_data[w_index] <= cpu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios with literal expectations, then
// randomized loads/stores against a transaction-level cache model.
module tb_dcache_ctrl;

  localparam int unsigned IB     = 4;
  localparam int unsigned CW     = 5;
  localparam int unsigned Lines  = 2 ** IB;
  localparam int          CntMax = 2 ** CW - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_rd = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [31:0]   cpu_addr = 32'h0;
  logic [31:0]   cpu_wdata = 32'h0;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_wr;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  dcache_ctrl #(.INDEX_BITS(IB), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache model: per-index word address, data and valid; one outstanding transaction.
  bit          m_valid [Lines];
  logic [29:0] m_line  [Lines];
  logic [31:0] m_data  [Lines];
  logic [31:0] m_fill;
  int          m_hits, m_misses;
  bit          m_pending, m_pend_rd, m_done;

  always @(negedge clk) begin : model
    int          idx;
    bit          hit, idle;
    logic [31:0] exp_rd;
    if (rst) begin
      for (int i = 0; i < Lines; i++) m_valid[i] = 1'b0;
      m_fill = 32'h0; m_hits = 0; m_misses = 0;
      m_pending = 1'b0; m_done = 1'b0;
    end else begin
      idx  = int'(cpu_addr[IB+1:2]);
      hit  = m_valid[idx] && (m_line[idx] == cpu_addr[31:2]);
      idle = !m_pending && !m_done;
      check("stall", stall, m_pending || (idle && (cpu_wr || (cpu_rd && !hit))));
      check("mem_req", mem_req, m_pending);
      if (m_pending) begin
        check("mem_wr", mem_wr, !m_pend_rd);
        check("mem_addr", mem_addr, {cpu_addr[31:2], 2'b00});
        if (!m_pend_rd) check("mem_wdata", mem_wdata, cpu_wdata);
      end
      if (!(idle && cpu_rd && cpu_wr)) begin
        if (m_done) exp_rd = m_fill;
        else if (idle && cpu_rd && hit) exp_rd = m_data[idx];
        else exp_rd = 32'h0;
        check("cpu_rdata", cpu_rdata, exp_rd);
      end
      check("hit_count", 32'(hit_count), m_hits);
      check("miss_count", 32'(miss_count), m_misses);
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_pending) begin
        if (mem_ack) begin
          if (m_pend_rd) begin
            m_valid[idx] = 1'b1;
            m_line[idx]  = cpu_addr[31:2];
            m_data[idx]  = mem_rdata;
            m_fill       = mem_rdata;
          end
          m_pending = 1'b0;
          m_done    = 1'b1;
        end
      end else if (cpu_wr) begin
        if (hit) m_data[idx] = cpu_wdata;
        m_pending = 1'b1; m_pend_rd = 1'b0;
      end else if (cpu_rd) begin
        if (hit) begin
          if (m_hits < CntMax) m_hits++;
        end else begin
          if (m_misses < CntMax) m_misses++;
          m_pending = 1'b1; m_pend_rd = 1'b1;
        end
      end
    end
  end

  // Backing-memory responder: ack on the ack_lat-th cycle of mem_req.
  int          ack_lat = 1;
  int          req_cnt = 0;
  int          req_rises = 0;
  bit          fixed_data = 1'b1;
  logic [31:0] ack_data = 32'h0;
  bit          spur = 1'b0;
  bit          rand_spur = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    mem_rdata = fixed_data ? ack_data : $urandom;
    if (mem_req) begin
      req_cnt++;
      if (req_cnt == 1) req_rises++;
      mem_ack = (req_cnt == ack_lat);
    end else begin
      req_cnt = 0;
      mem_ack = spur || (rand_spur && ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat,
                        output int stalls, output logic [31:0] rdata);
    bit done;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; ack_lat = lat;
    stalls = 0; done = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      else begin
        done  = 1'b1;
        rdata = cpu_rdata;
      end
      step();
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL req_timeout: stall still %b want 0 within 64 cycles", stall);
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    int          rises;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_hits", 32'(hit_count), 0);
    check("rst_misses", 32'(miss_count), 0);
    step();

    // Load miss with ack on third mem_req cycle, then hit.
    ack_data = 32'hDEAD_BEEF;
    do_req(1, 0, 32'h40, 0, 3, st, rd);
    check("t1_stall_cycles", st, 4);
    check("t1_fill_data", rd, 32'hDEAD_BEEF);
    check("t1_misses", 32'(miss_count), 1);
    do_req(1, 0, 32'h40, 0, 1, st, rd);
    check("t1_hit_stall", st, 0);
    check("t1_hit_data", rd, 32'hDEAD_BEEF);
    check("t1_hits", 32'(hit_count), 1);

    // Store hit updates the line.
    ack_data = 32'h0BAD_0BAD;
    do_req(0, 1, 32'h40, 32'h1234_5678, 1, st, rd);
    check("t2_store_stall", st, 2);
    do_req(1, 0, 32'h40, 0, 1, st, rd);
    check("t2_hit_stall", st, 0);
    check("t2_hit_data", rd, 32'h1234_5678);

    // Store miss does not allocate.
    do_req(0, 1, 32'h80, 32'h5555_AAAA, 2, st, rd);
    ack_data = 32'h0000_0080;
    do_req(1, 0, 32'h80, 0, 1, st, rd);
    check("t3_load_stall", st, 2);
    check("t3_load_data", rd, 32'h0000_0080);
    check("t3_misses", 32'(miss_count), 2);

    // Aliasing lines replace each other.
    ack_data = 32'h0000_0040;
    do_req(1, 0, 32'h40, 0, 1, st, rd);
    ack_data = 32'hCAFE_0440;
    do_req(1, 0, 32'h440, 0, 2, st, rd);
    check("t4_alias_data", rd, 32'hCAFE_0440);
    do_req(1, 0, 32'h40, 0, 1, st, rd);
    check("t4_reload_stall", st, 2);
    check("t4_misses", 32'(miss_count), 5);

    // Reset mid-miss, followed by a stray ack.
    cpu_rd = 1'b1; cpu_addr = 32'h100; ack_lat = 100;
    step(); step(); step();
    cpu_rd = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; spur = 1'b1;
    step();
    spur = 1'b0;
    @(negedge clk);
    check("t5_mem_req", mem_req, 1'b0);
    check("t5_stall", stall, 1'b0);
    check("t5_counts", 32'({hit_count, miss_count}), 0);
    step();
    ack_data = 32'h4040_4040;
    do_req(1, 0, 32'h40, 0, 1, st, rd);
    check("t5_reload_stall", st, 2);
    check("t5_misses", 32'(miss_count), 1);

    // Simultaneous read and write: one write transaction.
    rises = req_rises;
    do_req(1, 1, 32'h40, 32'hA5A5_0606, 1, st, rd);
    check("t6_stall_cycles", st, 2);
    check("t6_hits", 32'(hit_count), 0);
    check("t6_misses", 32'(miss_count), 1);
    @(negedge clk);
    check("t6_no_reissue", mem_req, 1'b0);
    step();
    @(negedge clk);
    check("t6_no_reissue2", mem_req, 1'b0);
    check("t6_single_req", req_rises - rises, 1);
    step();
    do_req(1, 0, 32'h40, 0, 1, st, rd);
    check("t6_hit_data", rd, 32'hA5A5_0606);

    // Randomized traffic, including stray acks and occasional resets.
    fixed_data = 1'b0;
    rand_spur  = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      int          kind;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      addr = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
             32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h8000_0000;
      if (kind < 2) begin
        cpu_addr = addr;
        step();
      end else if (kind < 6) begin
        do_req(1, 0, addr, 0, $urandom_range(1, 4), st, rd);
      end else if (kind < 9) begin
        do_req(0, 1, addr, $urandom, $urandom_range(1, 4), st, rd);
      end else begin
        do_req(1, 1, addr, $urandom, $urandom_range(1, 4), st, rd);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
